// File: rtl/splitter.sv
// ---------------------------------------------------------------------------
// splitter
//   Takes one 2*WIDTH word from channel S. Sends its low half on channel A
//   and its high half on channel B. The two consumers drain on their own
//   schedules: A may complete while B stalls, or B while A stalls. A new
//   word is accepted only once both output slots can take it. This keeps
//   the halves of different words from interleaving.
//
// Ports
//   clk      : clock, all state updates on its rising edge
//   reset    : asynchronous, active-low reset
//   S_valid  : input word valid
//   S_ready  : input word accepted this cycle when S_valid && S_ready
//   S_data   : input word, 2*WIDTH bits
//   A_valid  : low-half output valid (registered)
//   A_ready  : low-half consumer ready
//   A_data   : low half, S_data[WIDTH-1:0] (registered)
//   B_valid  : high-half output valid (registered)
//   B_ready  : high-half consumer ready
//   B_data   : high half, S_data[2*WIDTH-1:WIDTH] (registered)
//   count    : number of S words accepted since reset, mod 2^CNT_W
//
// Channel handshake: a transfer happens on a rising edge where valid and
// ready are both high. Once a producer raises valid, it holds valid and data
// steady until that transfer. Ready may change freely. Valid never depends
// on ready combinationally.
// ---------------------------------------------------------------------------
module splitter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               S_valid,
  output logic               S_ready,
  input  logic [2*WIDTH-1:0] S_data,
  output logic               A_valid,
  input  logic               A_ready,
  output logic [WIDTH-1:0]   A_data,
  output logic               B_valid,
  input  logic               B_ready,
  output logic [WIDTH-1:0]   B_data,
  output logic [CNT_W-1:0]   count
);

  // Output slot registers; the ports are driven straight from these.
  logic               a_valid_q;
  logic [WIDTH-1:0]   a_data_q;
  logic               b_valid_q;
  logic [WIDTH-1:0]   b_data_q;
  logic [CNT_W-1:0]   count_q;

  // A slot is free when it is empty, or when its current half leaves this cycle.
  logic free_a;
  logic free_b;
  logic accept;

  always_comb begin
    free_a = !a_valid_q || A_ready;
    free_b = !b_valid_q || B_ready;
  end

  // Both slots must be free together. A word is never split across cycles,
  // so A and B always carry halves of the same word.
  // The reset term forces S_ready low during reset, even though the slots
  // are already cleared then.
  assign S_ready = reset && free_a && free_b;
  assign accept  = S_valid && S_ready;

  // Low-half slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
    end else if (accept) begin
      // Reloads even if the previous half drains this same cycle.
      a_valid_q <= 1'b1;
      a_data_q  <= S_data[WIDTH-1:0];
    end else if (a_valid_q && A_ready) begin
      a_valid_q <= 1'b0;
    end
  end

  // High-half slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else if (accept) begin
      b_valid_q <= 1'b1;
      b_data_q  <= S_data[2*WIDTH-1:WIDTH];
    end else if (b_valid_q && B_ready) begin
      b_valid_q <= 1'b0;
    end
  end

  // Accepted-word counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign A_valid = a_valid_q;
  assign A_data  = a_data_q;
  assign B_valid = b_valid_q;
  assign B_data  = b_data_q;
  assign count   = count_q;

endmodule
